// File: rtl/uart_prog_loader.sv
// UART receiver that assembles big-endian 32-bit words and writes them to instruction memory.
// Programming stops when END_MARKER arrives; framing and overflow errors are sticky.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 86,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter logic [31:0] END_MARKER   = 32'h0000_0FFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  prog_done_o,
    output logic                  frame_err_o,
    output logic                  ovf_o
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] HalfMax = TimerW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TimerW-1:0] BitMax  = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q;
    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic [TimerW-1:0]     timer_q;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           word_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  full_q;
    logic [31:0]           word_next;

    // Byte 0 ends up in [31:24] after four left shifts.
    assign word_next = {word_q[23:0], shift_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            full_q      <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            prog_done_o <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        state_q <= StStart;
                        timer_q <= '0;
                    end
                end
                StStart: begin
                    if (timer_q == HalfMax) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? StIdle : StData;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StData: begin
                    if (timer_q == BitMax) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StStop: begin
                    if (timer_q == BitMax) begin
                        timer_q <= '0;
                        state_q <= StIdle;
                        // Once programming is done the line is ignored entirely.
                        if (!prog_done_o) begin
                            if (!rx_sync_q) begin
                                frame_err_o <= 1'b1;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                word_q     <= word_next;
                                if (byte_cnt_q == 2'd3) begin
                                    if (word_next == END_MARKER) begin
                                        prog_done_o <= 1'b1;
                                    end else if (full_q) begin
                                        ovf_o <= 1'b1;
                                    end else begin
                                        mem_we_o    <= 1'b1;
                                        mem_addr_o  <= addr_q;
                                        mem_wdata_o <= word_next;
                                        addr_q      <= addr_q + 1'b1;
                                        if (addr_q == '1) begin
                                            full_q <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 86, meaning clk_i cycles per UART bit (8600 ns bit at 100 ns clock).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning the instruction-memory word-address width (16384 words).
REQ-003 SHALL have parameter END_MARKER, default 32'h00000FFF, meaning the terminating word that ends programming.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port rx_i, input, 1 bit: UART serial line, idle high, asynchronous to clk_i.
REQ-007 SHALL have port mem_we_o, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-008 SHALL have port mem_addr_o, output, ADDR_WIDTH bits: word address of the write.
REQ-009 SHALL have port mem_wdata_o, output, 32 bits: assembled instruction word.
REQ-010 SHALL have port prog_done_o, output, 1 bit: END_MARKER received; level, sticky until reset.
REQ-011 SHALL have port frame_err_o, output, 1 bit: sticky flag set by any invalid stop bit.
REQ-012 SHALL have port ovf_o, output, 1 bit: sticky flag set when a word arrives after the last address was written.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 SHALL implement the receiver FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-015 IDLE: a synchronized 0 SHALL move the FSM to START and clear the bit-timer.
REQ-016 START: at timer = CLKS_PER_BIT/2 - 1, a sampled 0 SHALL move the FSM to DATA with timer cleared; a sampled 1 (glitch) SHALL return it to IDLE.
REQ-017 DATA: the line SHALL be sampled every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; after bit 7 the FSM SHALL move to STOP.
REQ-018 STOP: the line SHALL be sampled after CLKS_PER_BIT cycles; 1 SHALL deliver the byte, 0 SHALL discard it and set frame_err_o; either case SHALL return the FSM to IDLE.
REQ-019 The receiver SHALL tolerate a start bit up to 1000 ns (10 cycles) longer than nominal, with all data and stop samples landing inside their bits.
REQ-020 The assembler SHALL collect 4 delivered bytes MSB first: byte 0 -> [31:24], byte 3 -> [7:0]; a 2-bit byte counter SHALL wrap 3 -> 0.
REQ-021 A discarded (framing-error) byte SHALL NOT advance the byte counter.
REQ-022 On the 4th byte, if the word equals END_MARKER: set prog_done_o the next cycle and do not write.
REQ-023 On the 4th byte, if the word does not equal END_MARKER: assert mem_we_o for exactly one cycle, the cycle after the stop-bit sample, with mem_addr_o = current address and mem_wdata_o = word.
REQ-024 After a write the address SHALL increment by 1, starting at 0.
REQ-025 After a write at address 2^ADDR_WIDTH-1, any further non-marker word SHALL be dropped (no mem_we_o) and SHALL set ovf_o; the address SHALL NOT wrap.
REQ-026 Once prog_done_o = 1, all further bytes SHALL be ignored: no write, no flag change.
REQ-027 mem_addr_o and mem_wdata_o SHALL hold their last values when mem_we_o = 0.

Reset
REQ-028 Reset SHALL set the FSM to IDLE and clear the timer, byte counter, shift register, address and word.
REQ-029 Reset SHALL set mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, prog_done_o = 0, frame_err_o = 0, ovf_o = 0, and both synchronizer flops to 1.
REQ-030 Reset asserted mid-byte or mid-word SHALL discard the partial data; the next start bit SHALL begin byte 0 of word 0 at address 0.

Verification
REQ-031 Send bytes 12 34 56 78 (start bit +1000 ns) -> one mem_we_o pulse, addr 0, data 32'h12345678.
REQ-032 Send 3 words, then 00 00 0F FF -> writes at addr 0, 1, 2; prog_done_o = 1; no 4th write; later bytes produce no writes.
REQ-033 Byte AA with stop bit 0, then DE AD BE EF -> frame_err_o = 1; single write 32'hDEADBEEF at addr 0.
REQ-034 ADDR_WIDTH = 2, send 5 non-marker words -> writes at addr 0..3, 5th dropped, ovf_o = 1.
REQ-035 rx_i low for 20 cycles then high (glitch) -> FSM returns to IDLE; no byte delivered; no flags set.
REQ-036 rst_i pulsed after 2 bytes, then 01 02 03 04 sent -> write 32'h01020304 at addr 0; all flags 0.
